loadable_down_counter_8bit: RTL and testbench

- 8-bit synchronous down counter with parallel load, count enable and terminal-count flag.
- Used as a generic timeout, delay or event-countdown primitive.
- The terminal-count output `tc` signals that the counter has reached zero.

---
 rtl/loadable_down_counter_8bit_pkg.sv | 19 +
 rtl/loadable_down_counter_8bit_if.sv | 31 +++
 rtl/loadable_down_counter_8bit.sv | 62 ++++++
 tb/tb_loadable_down_counter_8bit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/loadable_down_counter_8bit_pkg.sv
// Shared constants and types for the 8-bit loadable down counter.
// The op enum names the action taken at the next clock edge.
package loadable_down_counter_8bit_pkg;

  localparam int WIDTH = 8;

  typedef logic [WIDTH-1:0] count_t;

  localparam count_t COUNT_ZERO = '0;
  localparam count_t COUNT_ONE  = count_t'(1);

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_DEC  = 2'd1,
    OP_SAT  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

endpackage

// File: rtl/loadable_down_counter_8bit_if.sv
// Control/data bundle for the loadable down counter.
// No handshake: load/enable/data_in are sampled on every rising edge, count/tc are always valid.
interface loadable_down_counter_8bit_if;
  import loadable_down_counter_8bit_pkg::*;

  logic   load;
  logic   enable;
  count_t data_in;
  count_t count;
  logic   tc;
  op_e    op;

  modport master (
    output load,
    output enable,
    output data_in,
    input  count,
    input  tc,
    input  op
  );

  modport slave (
    input  load,
    input  enable,
    input  data_in,
    output count,
    output tc,
    output op
  );

endinterface

// File: rtl/loadable_down_counter_8bit.sv
// 8-bit down counter: parallel load beats enable, saturates at zero, tc decodes count == 0.
// The pending edge action is exported on bus.op for observation.
module loadable_down_counter_8bit
  import loadable_down_counter_8bit_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  loadable_down_counter_8bit_if.slave bus
);

  count_t r_count;
  op_e    w_op;

  always_comb begin
    w_op = OP_HOLD;
    if (bus.load) begin
      w_op = OP_LOAD;
    end else if (bus.enable) begin
      w_op = (r_count == COUNT_ZERO) ? OP_SAT : OP_DEC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= COUNT_ZERO;
    end else begin
      case (w_op)
        OP_LOAD: r_count <= bus.data_in;
        OP_DEC:  r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = (r_count == COUNT_ZERO);
  assign bus.op    = w_op;

  // Checkers are disabled while reset is low so an async reset never trips them.
  property p_load_priority;
    @(posedge clk) disable iff (!rst)
      bus.load |=> (r_count == $past(bus.data_in));
  endproperty
  a_load_priority: assert property (p_load_priority);

  property p_saturate;
    @(posedge clk) disable iff (!rst)
      (!bus.load && bus.enable && r_count == COUNT_ZERO) |=> (r_count == COUNT_ZERO);
  endproperty
  a_saturate: assert property (p_saturate);

  property p_tc_decode;
    @(posedge clk) bus.tc == (r_count == COUNT_ZERO);
  endproperty
  a_tc_decode: assert property (p_tc_decode);

  property p_reset_clears;
    @(posedge clk) !rst |-> (r_count == COUNT_ZERO);
  endproperty
  a_reset_clears: assert property (p_reset_clears);

endmodule

// File: tb/tb_loadable_down_counter_8bit.sv
// Bench for loadable_down_counter_8bit: directed plan plus random traffic,
// with expected {tc,count} pushed at stimulus time and popped by a monitor after each edge.
module tb_loadable_down_counter_8bit;
  import loadable_down_counter_8bit_pkg::*;

  logic clk;
  logic rst;

  loadable_down_counter_8bit_if bus ();

  loadable_down_counter_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  int         model_count;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    bus.load    = 1'b0;
    bus.enable  = 1'b0;
    bus.data_in = 8'h00;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: applies one edge worth of inputs and records the expected result
  task automatic cycle(input logic rst_v, input logic ld, input logic en, input logic [7:0] d);
    @(negedge clk);
    rst         = rst_v;
    bus.load    = ld;
    bus.enable  = en;
    bus.data_in = d;
    if (!rst_v)        model_count = 0;
    else if (ld)       model_count = int'(d);
    else if (en)       model_count = (model_count > 0) ? model_count - 1 : 0;
    exp_q.push_back({(model_count == 0), 8'(model_count)});
  endtask

  // monitor / scoreboard
  initial begin
    logic [8:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("count", int'(bus.count), int'(exp[7:0]));
        check("tc", int'(bus.tc), int'(exp[8]));
      end
    end
  end

  initial begin
    int first_tc;
    model_count = 0;

    // reset is asynchronous: count clears before any clock edge
    #2 rst = 1'b0;
    #1;
    check("reset_async_count", int'(bus.count), 0);
    check("reset_async_tc", int'(bus.tc), 1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // load 5, count to zero, then saturate
    cycle(1'b1, 1'b1, 1'b0, 8'h05);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));

    // load wins over enable, then hold
    cycle(1'b1, 1'b1, 1'b1, 8'hA0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));

    // async reset mid-count at 0x37
    cycle(1'b1, 1'b1, 1'b0, 8'h38);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #2;
    check("pre_reset_count", int'(bus.count), 'h37);
    rst = 1'b0;
    #1;
    check("mid_reset_count", int'(bus.count), 0);
    check("mid_reset_tc", int'(bus.tc), 1);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);

    // full range: tc first asserts on the 255th enabled edge
    cycle(1'b1, 1'b1, 1'b0, 8'hFF);
    first_tc = 0;
    for (int i = 1; i <= 255; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
      @(posedge clk);
      #2;
      if (bus.tc && first_tc == 0) first_tc = i;
    end
    check("first_tc_edge", first_tc, 255);
    cycle(1'b1, 1'b1, 1'b0, 8'h09);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic          r_v;
      logic          ld;
      logic          en;
      logic [7:0]    d;
      r_v = ($urandom_range(0, 39) != 0);
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      cycle(r_v, ld, en, d);
    end
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
